keccak_pad_feeder: RTL and testbench

KECCAK_PAD_FEEDER -- requirements
Module: keccak_pad_feeder

---
 rtl/keccak_pad_feeder.sv | 191 +++++++++++++++++++
 tb/tb_keccak_pad_feeder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_pad_feeder.sv
// Keccak padding feeder: packs byte-granular message words into rate-sized blocks,
// applies SHA3/SHAKE multi-rate padding and streams lanes to the permutation core.
module keccak_pad_feeder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_start,
  input  logic [2:0]  cmode,
  input  logic [63:0] msg_data,
  input  logic [3:0]  msg_bytes,
  input  logic        msg_valid,
  input  logic        msg_last,
  output logic        msg_ready,
  output logic        core_start,
  input  logic        core_req,
  output logic [63:0] dt_o,
  output logic        last_block,
  output logic        busy,
  output logic        err
);
  localparam int unsigned LANES     = 21;
  localparam int unsigned BUF_BYTES = LANES * 8;
  localparam int unsigned PTR_W     = 8;
  localparam int unsigned LANE_W    = 5;

  typedef enum logic [2:0] {IDLE, FILL, PAD, DRAIN, ERR} state_t;

  state_t            state_q, state_d;
  logic [7:0]        buf_q [BUF_BYTES];
  logic [7:0]        buf_d [BUF_BYTES];
  logic [2:0]        mode_q, mode_d;
  logic [PTR_W-1:0]  byte_ptr_q, byte_ptr_d;
  logic [LANE_W-1:0] lane_ptr_q, lane_ptr_d;
  logic              last_q, last_d;
  logic              pad_pend_q, pad_pend_d;
  logic              started_q, started_d;
  logic              cs_q, cs_d;
  logic              err_q, err_d;

  logic [LANE_W-1:0] rl;
  logic [PTR_W-1:0]  rb;
  logic [PTR_W-1:0]  fill_ptr;
  logic [7:0]        dom;

  function automatic logic [LANE_W-1:0] rate_lanes(input logic [2:0] m);
    case (m)
      3'd0:    rate_lanes = LANE_W'(18);
      3'd1:    rate_lanes = LANE_W'(17);
      3'd2:    rate_lanes = LANE_W'(13);
      3'd3:    rate_lanes = LANE_W'(9);
      3'd4:    rate_lanes = LANE_W'(21);
      3'd5:    rate_lanes = LANE_W'(17);
      default: rate_lanes = LANE_W'(0);
    endcase
  endfunction

  assign rl       = rate_lanes(mode_q);
  assign rb       = {rl, 3'b000};
  assign fill_ptr = byte_ptr_q + PTR_W'(msg_bytes);
  assign dom      = (mode_q >= 3'd4) ? 8'h1F : 8'h06;

  // Next-state, buffer update and control
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    byte_ptr_d = byte_ptr_q;
    lane_ptr_d = lane_ptr_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;
    started_d  = started_q;
    cs_d       = 1'b0;
    err_d      = err_q;
    buf_d      = buf_q;

    if (core_req && (state_q != DRAIN)) err_d = 1'b1;

    case (state_q)
      IDLE, ERR: begin
        if (msg_start) begin
          if (cmode <= 3'd5) begin
            state_d    = FILL;
            mode_d     = cmode;
            byte_ptr_d = '0;
            lane_ptr_d = '0;
            last_d     = 1'b0;
            pad_pend_d = 1'b0;
            started_d  = 1'b0;
            buf_d      = '{default: 8'h00};
            if (state_q == ERR) err_d = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      FILL: begin
        if (msg_valid) begin
          if ((msg_bytes > 4'd8) || ((msg_bytes != 4'd8) && !msg_last)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            for (int b = 0; b < 8; b++) begin
              if ((4'(b) < msg_bytes) && ((int'(byte_ptr_q) + b) < int'(BUF_BYTES)))
                buf_d[PTR_W'(int'(byte_ptr_q) + b)] = msg_data[8*b +: 8];
            end
            byte_ptr_d = fill_ptr;
            if (fill_ptr == rb) begin
              // A last word that exactly fills the block still owes a pad-only block
              state_d    = DRAIN;
              lane_ptr_d = '0;
              last_d     = 1'b0;
              pad_pend_d = msg_last;
              cs_d       = !started_q;
              started_d  = 1'b1;
            end else if (msg_last) begin
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        buf_d[byte_ptr_q] = buf_d[byte_ptr_q] | dom;
        buf_d[rb - 8'd1]  = buf_d[rb - 8'd1] | 8'h80;
        state_d    = DRAIN;
        lane_ptr_d = '0;
        last_d     = 1'b1;
        pad_pend_d = 1'b0;
        cs_d       = !started_q;
        started_d  = 1'b1;
      end
      DRAIN: begin
        if (core_req) begin
          if (lane_ptr_q == rl - LANE_W'(1)) begin
            lane_ptr_d = '0;
            byte_ptr_d = '0;
            if (last_q) begin
              state_d = IDLE;
              last_d  = 1'b0;
            end else begin
              buf_d   = '{default: 8'h00};
              state_d = pad_pend_q ? PAD : FILL;
            end
          end else begin
            lane_ptr_d = lane_ptr_q + LANE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      byte_ptr_q <= '0;
      lane_ptr_q <= '0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
      started_q  <= 1'b0;
      cs_q       <= 1'b0;
      err_q      <= 1'b0;
      buf_q      <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      byte_ptr_q <= byte_ptr_d;
      lane_ptr_q <= lane_ptr_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
      started_q  <= started_d;
      cs_q       <= cs_d;
      err_q      <= err_d;
      buf_q      <= buf_d;
    end
  end

  // Lane presented to the core is a direct read of the current drain lane
  always_comb begin
    dt_o = '0;
    if (state_q == DRAIN) begin
      for (int k = 0; k < 8; k++)
        dt_o[8*k +: 8] = buf_q[PTR_W'({lane_ptr_q, 3'b000}) + PTR_W'(k)];
    end
  end

  assign msg_ready  = (state_q == FILL);
  assign busy       = (state_q == FILL) || (state_q == PAD) || (state_q == DRAIN);
  assign core_start = cs_q;
  assign last_block = last_q;
  assign err        = err_q;
endmodule

// File: tb/tb_keccak_pad_feeder.sv
// Self-checking bench for keccak_pad_feeder: scoreboard of expected lanes per message,
// directed padding vectors, randomized multi-block messages, error and reset scenarios.
module tb_keccak_pad_feeder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg_start = 1'b0;
  logic [2:0]  cmode = '0;
  logic [63:0] msg_data = '0;
  logic [3:0]  msg_bytes = '0;
  logic        msg_valid = 1'b0;
  logic        msg_last = 1'b0;
  logic        core_req = 1'b0;
  logic        msg_ready, core_start, last_block, busy, err;
  logic [63:0] dt_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] d;
    logic        lb;
    logic        cs;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg[$];

  always #5 clk = ~clk;

  keccak_pad_feeder dut (
    .clk(clk), .rst_n(rst_n), .msg_start(msg_start), .cmode(cmode),
    .msg_data(msg_data), .msg_bytes(msg_bytes), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_ready(msg_ready), .core_start(core_start),
    .core_req(core_req), .dt_o(dt_o), .last_block(last_block), .busy(busy), .err(err)
  );

  function automatic int rate_of(input int m);
    case (m)
      0: return 18;
      1: return 17;
      2: return 13;
      3: return 9;
      4: return 21;
      default: return 17;
    endcase
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic lb, input logic cs);
    exp_t e;
    e.d = d; e.lb = lb; e.cs = cs;
    sb.push_back(e);
  endtask

  // Reference padding: msg || dom || 0* || 0x80 over whole rate blocks
  task automatic push_model(input int m);
    int rb, n, nblk;
    logic [7:0] p[$];
    logic [63:0] lane;
    rb = rate_of(m) * 8;
    n = msg.size();
    nblk = n / rb + 1;
    for (int i = 0; i < nblk * rb; i++) p.push_back((i < n) ? msg[i] : 8'h00);
    p[n] = p[n] | ((m >= 4) ? 8'h1F : 8'h06);
    p[nblk*rb-1] = p[nblk*rb-1] | 8'h80;
    for (int b = 0; b < nblk; b++)
      for (int l = 0; l < rate_of(m); l++) begin
        lane = '0;
        for (int k = 0; k < 8; k++) lane[8*k +: 8] = p[b*rb + l*8 + k];
        push_exp(lane, (b == nblk - 1), (b == 0 && l == 0));
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    core_req = 1'b0; msg_valid = 1'b0; msg_start = 1'b0; msg_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic start_msg(input int m);
    @(negedge clk);
    cmode = 3'(m);
    msg_start = 1'b1;
    @(posedge clk);
    #1 msg_start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
    int cnt;
    msg_data = d; msg_bytes = nb; msg_last = last; msg_valid = 1'b1;
    cnt = 0;
    while (!msg_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (msg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL word_accept_timeout: msg_ready=%b required 1", msg_ready);
    end
    @(posedge clk);
    #1 msg_valid = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic drain_block(input int rl, input int pre);
    exp_t e;
    repeat (pre) @(posedge clk);
    for (int l = 0; l < rl; l++) begin
      @(negedge clk);
      core_req = 1'b1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: lane %0d has no expected entry", l);
      end else begin
        e = sb.pop_front();
        n_checks += 2;
        if (dt_o !== e.d) begin
          n_fail++;
          $display("FAIL lane_data[%0d]: got %h required %h", l, dt_o, e.d);
        end
        if (last_block !== e.lb) begin
          n_fail++;
          $display("FAIL last_block[%0d]: got %b required %b", l, last_block, e.lb);
        end
        if (core_start !== e.cs) begin
          n_fail++;
          $display("FAIL core_start[%0d]: got %b required %b", l, core_start, e.cs);
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    core_req = 1'b0;
  endtask

  task automatic run_msg(input int m);
    int rl, n, nw, nb, fill;
    logic [63:0] d;
    logic last;
    rl = rate_of(m); n = msg.size(); nw = (n == 0) ? 1 : (n + 7) / 8; fill = 0;
    start_msg(m);
    for (int w = 0; w < nw; w++) begin
      nb = (n - 8*w > 8) ? 8 : n - 8*w;
      last = (w == nw - 1);
      d = {$urandom, $urandom};
      for (int k = 0; k < nb; k++) d[8*k +: 8] = msg[8*w + k];
      send_word(d, 4'(nb), last);
      fill += nb;
      if (fill == rl * 8) begin
        drain_block(rl, 0);
        fill = 0;
        if (last) drain_block(rl, 1);
      end else if (last) begin
        drain_block(rl, 1);
      end
    end
    n_checks += 2;
    if (busy !== 1'b0 || last_block !== 1'b0) begin
      n_fail++;
      $display("FAIL end_of_msg: busy=%b last_block=%b required 0 0", busy, last_block);
    end
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_lanes: %0d expected lanes not drained", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 3;
    if ({msg_ready, core_start, last_block, busy, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000", {msg_ready, core_start, last_block, busy, err});
    end
    if (dt_o !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_dt: got %h required 0", dt_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    if ({msg_ready, busy, err} !== 3'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required 000", {msg_ready, busy, err});
    end
  endtask

  task automatic test_empty_sha3_256();
    msg.delete();
    for (int l = 0; l < 17; l++)
      push_exp((l == 0) ? 64'h6 : (l == 16) ? 64'h8000000000000000 : 64'h0, 1'b1, (l == 0));
    run_msg(1);
  endtask

  task automatic test_sha3_512_full();
    msg.delete();
    for (int i = 0; i < 72; i++) msg.push_back(8'hFF);
    for (int l = 0; l < 9; l++) push_exp(64'hFFFFFFFFFFFFFFFF, 1'b0, (l == 0));
    for (int l = 0; l < 9; l++)
      push_exp((l == 0) ? 64'h6 : (l == 8) ? 64'h8000000000000000 : 64'h0, 1'b1, 1'b0);
    run_msg(3);
  endtask

  task automatic test_shake128_167();
    msg.delete();
    for (int i = 0; i < 167; i++) msg.push_back(8'h00);
    for (int l = 0; l < 21; l++) push_exp((l == 20) ? 64'h9F00000000000000 : 64'h0, 1'b1, (l == 0));
    run_msg(4);
  endtask

  task automatic test_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    for (int l = 0; l < 17; l++)
      push_exp((l == 0) ? 64'h0000000006636261 : (l == 16) ? 64'h8000000000000000 : 64'h0,
               1'b1, (l == 0));
    run_msg(1);
  endtask

  task automatic test_back_to_back();
    int len;
    for (int t = 0; t < 6; t++) begin
      len = (t % 2 == 0) ? int'($urandom_range(1, 400)) : rate_of(t) * 8 * (1 + t % 3);
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      push_model(t);
      run_msg(t);
    end
  endtask

  task automatic test_errors();
    do_reset();
    start_msg(6);
    n_checks += 2;
    if (err !== 1'b1 || msg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_mode: err=%b msg_ready=%b required 1 0", err, msg_ready);
    end
    if (busy !== 1'b0 || dt_o !== 64'h0) begin
      n_fail++;
      $display("FAIL illegal_mode_idle: busy=%b dt_o=%h required 0 0", busy, dt_o);
    end
    start_msg(1);
    n_checks++;
    if (err !== 1'b0 || msg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL err_recover: err=%b msg_ready=%b required 0 1", err, msg_ready);
    end
    send_word(64'h1122334455667788, 4'd5, 1'b0);
    n_checks++;
    if (err !== 1'b1 || msg_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL short_word: err=%b ready=%b busy=%b required 1 0 0", err, msg_ready, busy);
    end
    do_reset();
    @(negedge clk);
    core_req = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1 || dt_o !== 64'h0) begin
      n_fail++;
      $display("FAIL underrun: err=%b dt_o=%h required 1 0", err, dt_o);
    end
    @(negedge clk);
    core_req = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_drain();
    logic [63:0] d, lane4;
    do_reset();
    msg.delete();
    for (int i = 0; i < 40; i++) msg.push_back(8'($urandom_range(1, 255)));
    lane4 = '0;
    for (int k = 0; k < 8; k++) lane4[8*k +: 8] = msg[32 + k];
    start_msg(3);
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = msg[8*w + k];
      send_word(d, 4'd8, (w == 4));
    end
    @(posedge clk);
    for (int l = 0; l < 4; l++) begin
      @(negedge clk);
      core_req = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (dt_o !== lane4 || busy !== 1'b1 || last_block !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_lane4: dt_o=%h busy=%b lb=%b required %h 1 1", dt_o, busy, last_block, lane4);
    end
    #1 rst_n = 1'b0;
    core_req = 1'b0;
    #1;
    n_checks++;
    if (dt_o !== 64'h0 || {msg_ready, core_start, last_block, busy, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: dt_o=%h ctrl=%b required 0 00000", dt_o,
               {msg_ready, core_start, last_block, busy, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    msg.delete();
    for (int i = 0; i < 11; i++) msg.push_back(8'($urandom));
    push_model(3);
    run_msg(3);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_empty_sha3_256();
    test_sha3_512_full();
    test_shake128_167();
    test_abc();
    test_back_to_back();
    test_errors();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
